fpu_issue_ctrl: RTL

- Upstream issue/collect stage for the parameterised fpu core.
- Accepts one operation at a time over a valid/ready handshake and drives fpu_op, fpu_rmode, opa and opb into the core.
- Counts the core's fixed per-operation latency, then captures out and the eight flags, and returns them with a tag over a second valid/ready handshake.
- Exactly one operation is in flight; the core is never re-driven mid-operation.

---
 rtl/fpu_pkg.sv | 44 ++++
 rtl/fpu_lat_counter.sv | 29 ++
 rtl/fpu_issue_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issue/collect slice: opcodes, rounding modes,
// controller state encoding, flag bit positions and latency selection.
package fpu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam logic [1:0] RM_NEAREST = 2'd0;
  localparam logic [1:0] RM_ZERO    = 2'd1;
  localparam logic [1:0] RM_UP      = 2'd2;
  localparam logic [1:0] RM_DOWN    = 2'd3;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_BUSY = 2'd1,
    FSM_DONE = 2'd2
  } fsm_state_e;

  // Bit positions inside the 8-bit flag vector {snan .. zero}.
  localparam int unsigned FLAG_ZERO        = 0;
  localparam int unsigned FLAG_DIV_BY_ZERO = 1;
  localparam int unsigned FLAG_UNDERFLOW   = 2;
  localparam int unsigned FLAG_OVERFLOW    = 3;
  localparam int unsigned FLAG_INE         = 4;
  localparam int unsigned FLAG_INF         = 5;
  localparam int unsigned FLAG_QNAN        = 6;
  localparam int unsigned FLAG_SNAN        = 7;

  // add/sub/mul use the short pipeline; div and unused codes use the long one.
  function automatic logic [3:0] lat_for_op(input logic [2:0] op,
                                            input logic [3:0] lat_asm,
                                            input logic [3:0] lat_div);
    logic [3:0] lat_v;
    if (op < OP_DIV) begin
      lat_v = lat_asm;
    end else begin
      lat_v = lat_div;
    end
    return lat_v;
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable 4-bit down-counter; done is high while the count sits at 1,
// marking the last cycle of the operation's latency.
module fpu_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] count_r;

  // Load has priority; decrement stops at zero so an idle counter stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 4'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == 4'd1);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/collect controller for the fpu core: one operation in flight, fixed latency count.
// Optional FPU_ISSUE_STICKY_EN adds accumulated sticky_flags with a sticky_clr input.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int BIT_SIZE = 15,
  parameter int LAT_ASM  = 4,
  parameter int LAT_DIV  = 12,
  parameter int TAG_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [1:0]          in_rmode,
  input  logic [BIT_SIZE:0]   in_a,
  input  logic [BIT_SIZE:0]   in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic [2:0]          fpu_op,
  output logic [1:0]          fpu_rmode,
  output logic [BIT_SIZE:0]   opa,
  output logic [BIT_SIZE:0]   opb,
  input  logic [BIT_SIZE:0]   fpu_out,
  input  logic [7:0]          fpu_flags,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE:0]   out_result,
  output logic [7:0]          out_flags,
  output logic [TAG_W-1:0]    out_tag
`ifdef FPU_ISSUE_STICKY_EN
 ,input  logic                sticky_clr,
  output logic [7:0]          sticky_flags
`endif
);

  localparam logic [1:0] S_IDLE = FSM_IDLE;
  localparam logic [1:0] S_BUSY = FSM_BUSY;
  localparam logic [1:0] S_DONE = FSM_DONE;

  if ((LAT_ASM < 1) || (LAT_ASM > 15)) begin : g_bad_lat_asm
    $error("fpu_issue_ctrl: LAT_ASM=%0d outside 1..15", LAT_ASM);
  end
  if ((LAT_DIV < 1) || (LAT_DIV > 15)) begin : g_bad_lat_div
    $error("fpu_issue_ctrl: LAT_DIV=%0d outside 1..15", LAT_DIV);
  end

  logic [1:0]       state_r;
  logic [TAG_W-1:0] tag_r;
  logic             load_s;
  logic             en_s;
  logic             done_s;
  logic [3:0]       lat_load_s;

  assign lat_load_s = lat_for_op(in_op, 4'(LAT_ASM), 4'(LAT_DIV));

  // Counter control: load on accept, count only while the core is working.
  always_comb begin
    load_s = 1'b0;
    en_s   = 1'b0;
    case (state_r)
      S_IDLE:  load_s = in_valid;
      S_BUSY:  en_s   = 1'b1;
      S_DONE:  en_s   = 1'b0;
      default: en_s   = 1'b0;
    endcase
  end

  fpu_lat_counter u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (lat_load_s),
    .en       (en_s),
    .done     (done_s)
  );

  // Main FSM: launch onto the core, capture at the end of latency, hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      fpu_op     <= 3'd0;
      fpu_rmode  <= 2'd0;
      opa        <= {(BIT_SIZE+1){1'b0}};
      opb        <= {(BIT_SIZE+1){1'b0}};
      tag_r      <= {TAG_W{1'b0}};
      out_result <= {(BIT_SIZE+1){1'b0}};
      out_flags  <= 8'd0;
      out_tag    <= {TAG_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            fpu_op    <= in_op;
            fpu_rmode <= in_rmode;
            opa       <= in_a;
            opb       <= in_b;
            tag_r     <= in_tag;
            in_ready  <= 1'b0;
            state_r   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (done_s) begin
            out_result <= fpu_out;
            out_flags  <= fpu_flags;
            out_tag    <= tag_r;
            out_valid  <= 1'b1;
            state_r    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FPU_ISSUE_STICKY_EN
  logic hs_s;
  assign hs_s = out_valid && out_ready;

  // A clear coinciding with a handshake keeps only that handshake's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= 8'd0;
    end else if (sticky_clr) begin
      sticky_flags <= hs_s ? out_flags : 8'd0;
    end else if (hs_s) begin
      sticky_flags <= sticky_flags | out_flags;
    end else begin
      sticky_flags <= sticky_flags;
    end
  end
`endif

endmodule
